// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: load-use stall, branch/jump flush and
// memory-stall freeze with saturating stall/flush performance counters.
module id_ex_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic             ex_jump,
    input  logic             ex_branch_taken,
    input  logic [4:0]       ex_rt_address,
    input  logic             mem_stall,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        STALL   = 2'b01,
        FLUSH   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t state_q;
    state_t next_state;

    logic load_use;
    logic redirect;
    logic run_like;
    logic rs_hit;
    logic rt_hit;
    logic stall_inc;
    logic flush_inc;

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Hazard detection; r0 is never a real dependency.
    always_comb begin
        rs_hit   = (ex_rt_address == id_rs_addr);
        rt_hit   = id_uses_rt & (ex_rt_address == id_rt_addr);
        load_use = ex_MemRead & (ex_rt_address != 5'd0) & (rs_hit | rt_hit);
        redirect = ex_jump | ex_branch_taken;
        // The unused encoding behaves like RUN for its one cycle.
        run_like = (state_q == RUN) | (state_q == ILLEGAL);
    end

    // Zero-latency control: mem_stall beats redirect beats load-use.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        next_state   = state_q;
        if (!reset) begin
            next_state = RUN;
        end else if (mem_stall) begin
            stall_inc = 1'b1;
            if (state_q == ILLEGAL) begin
                next_state = RUN;
            end
        end else if (redirect) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            id_ex_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
            next_state  = FLUSH;
        end else if (load_use && run_like) begin
            // Hold PC and IF/ID, inject a bubble into EX.
            id_ex_write  = 1'b1;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            next_state   = (state_q == RUN) ? STALL : RUN;
        end else begin
            // STALL/FLUSH last one unfrozen cycle; EX holds a bubble,
            // so a load-use match there is stale and ignored.
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            id_ex_write = 1'b1;
            next_state  = RUN;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= next_state;
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (cnt_clr) begin
            stall_q <= '0;
        end else if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    // Saturating flush counter; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_q <= '0;
        end else if (cnt_clr) begin
            flush_q <= '0;
        end else if (flush_inc && (flush_q != {CNT_W{1'b1}})) begin
            flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
    assign state       = state_q;

endmodule
